// File: rtl/iq_phase_detector_if.sv
// Sample/result bundle for the IQ phase detector.
//
// Flow semantics: there is no backpressure. A sample is taken on a rising
// clock edge where en=1 and in_valid=1. A result is presented while
// out_valid=1 and is consumed on the first rising edge where en=1. While
// en=0 every output, including out_valid, holds its value.
interface iq_phase_detector_if #(
    parameter int DW = 12,
    parameter int PW = 32
);
    logic                 en;
    logic                 in_valid;
    logic signed [DW-1:0] i_in;
    logic signed [DW-1:0] q_in;
    logic [PW-1:0]        phase_out;
    logic [DW+1:0]        mag_out;
    logic [PW-1:0]        freq_out;
    logic                 out_valid;

    // Sample source side (upstream mixer/filter or a testbench)
    modport master (
        output en,
        output in_valid,
        output i_in,
        output q_in,
        input  phase_out,
        input  mag_out,
        input  freq_out,
        input  out_valid
    );

    // Detector side
    modport slave (
        input  en,
        input  in_valid,
        input  i_in,
        input  q_in,
        output phase_out,
        output mag_out,
        output freq_out,
        output out_valid
    );
endinterface

// File: rtl/iq_phase_detector.sv
// Quadrature phase/magnitude/frequency detector: a fully pipelined CORDIC in
// vectoring mode. Phase and frequency use the DDS scaling (full circle =
// 2^PW). Magnitude carries the uncompensated CORDIC gain (~1.6468).
module iq_phase_detector #(
    parameter int DW   = 12,
    parameter int PW   = 32,
    parameter int ITER = 16
) (
    input logic                clk,
    input logic                rst,
    iq_phase_detector_if.slave bus
);
    // Datapath: sign bit, DW-1 magnitude bits, gain growth headroom and two
    // guard fraction bits.
    localparam int  XW = DW + 4;
    localparam real PI = 3.14159265358979323846;

    // Elaboration-time arctangent table entry: round(atan(2^-k)/(2*pi) * 2^PW).
    function automatic logic [PW-1:0] atan_entry(input int k);
        real    t;
        real    scale;
        real    r;
        longint n;
        t = 1.0;
        for (int j = 0; j < k; j++) begin
            t = t / 2.0;
        end
        scale = 1.0;
        for (int j = 0; j < PW; j++) begin
            scale = scale * 2.0;
        end
        r = $atan(t) / (2.0 * PI) * scale;
        n = longint'(r);
        return n[PW-1:0];
    endfunction

    logic [PW-1:0] atan_tab [0:ITER-1];

    for (genvar k = 0; k < ITER; k++) begin : g_atan
        assign atan_tab[k] = atan_entry(k);
    end

    // ------------------------------------------------------------------
    // Input conditioning and quadrant fold
    // ------------------------------------------------------------------
    logic signed [XW-1:0] i_ext;
    logic signed [XW-1:0] q_ext;
    logic signed [XW-1:0] fold_x;
    logic signed [XW-1:0] fold_y;
    logic [PW-1:0]        fold_z;
    logic                 fold_zero;

    // Sign-extend by two and append two guard fraction bits. Negating the
    // most negative input is exact at this width.
    assign i_ext = {{2{bus.i_in[DW-1]}}, bus.i_in, 2'b00};
    assign q_ext = {{2{bus.q_in[DW-1]}}, bus.q_in, 2'b00};

    // Rotate left-half-plane vectors by 180 degrees so the micro-rotations
    // only have to cover +/-90 degrees.
    always_comb begin
        fold_x    = i_ext;
        fold_y    = q_ext;
        fold_z    = '0;
        fold_zero = (bus.i_in == '0) && (bus.q_in == '0);
        if (bus.i_in[DW-1]) begin
            fold_x = -i_ext;
            fold_y = -q_ext;
            fold_z = {1'b1, {(PW-1){1'b0}}};
        end
    end

    // ------------------------------------------------------------------
    // Micro-rotation pipeline
    // Index k of x_q/y_q/z_q/v_q/zf_q is the input of micro-rotation k;
    // index ITER is the final CORDIC result.
    // ------------------------------------------------------------------
    logic signed [XW-1:0] x_q  [0:ITER];
    logic signed [XW-1:0] y_q  [0:ITER];
    logic [PW-1:0]        z_q  [0:ITER];
    logic                 v_q  [0:ITER];
    logic                 zf_q [0:ITER];

    logic signed [XW-1:0] rot_x [0:ITER-1];
    logic signed [XW-1:0] rot_y [0:ITER-1];
    logic [PW-1:0]        rot_z [0:ITER-1];

    // Each stage drives y toward zero, accumulating the rotated angle in z.
    // Both x and y updates use the stage's incoming x/y.
    always_comb begin
        for (int k = 0; k < ITER; k++) begin
            rot_x[k] = x_q[k];
            rot_y[k] = y_q[k];
            rot_z[k] = z_q[k];
            if (!y_q[k][XW-1]) begin
                rot_x[k] = x_q[k] + (y_q[k] >>> k);
                rot_y[k] = y_q[k] - (x_q[k] >>> k);
                rot_z[k] = z_q[k] + atan_tab[k];
            end else begin
                rot_x[k] = x_q[k] - (y_q[k] >>> k);
                rot_y[k] = y_q[k] + (x_q[k] >>> k);
                rot_z[k] = z_q[k] - atan_tab[k];
            end
        end
    end

    // Pipeline registers: fold stage followed by ITER rotation stages,
    // advancing together only on enabled clocks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k <= ITER; k++) begin
                x_q[k]  <= '0;
                y_q[k]  <= '0;
                z_q[k]  <= '0;
                v_q[k]  <= 1'b0;
                zf_q[k] <= 1'b0;
            end
        end else if (bus.en) begin
            x_q[0]  <= fold_x;
            y_q[0]  <= fold_y;
            z_q[0]  <= fold_z;
            v_q[0]  <= bus.in_valid;
            zf_q[0] <= fold_zero;
            for (int k = 0; k < ITER; k++) begin
                x_q[k+1]  <= rot_x[k];
                y_q[k+1]  <= rot_y[k];
                z_q[k+1]  <= rot_z[k];
                v_q[k+1]  <= v_q[k];
                zf_q[k+1] <= zf_q[k];
            end
        end
    end

    // ------------------------------------------------------------------
    // Output stage: phase, magnitude and phase difference
    // ------------------------------------------------------------------
    logic [PW-1:0]   phase_new;
    logic [PW-1:0]   freq_new;
    logic [PW-1:0]   phase_r;
    logic [DW+1:0]   mag_r;
    logic [PW-1:0]   freq_r;
    logic            valid_r;
    logic [PW-1:0]   prev_phase;
    logic            first_flag;

    // A zero vector has no defined angle; report 0 rather than whatever the
    // rotations happened to accumulate. The first result after reset has no
    // predecessor, so its frequency is 0.
    always_comb begin
        phase_new = zf_q[ITER] ? '0 : z_q[ITER];
        freq_new  = first_flag ? '0 : (phase_new - prev_phase);
    end

    // Result registers; only a valid sample updates the outputs and the
    // phase history, so bubbles never disturb the frequency reference.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_r    <= '0;
            mag_r      <= '0;
            freq_r     <= '0;
            valid_r    <= 1'b0;
            prev_phase <= '0;
            first_flag <= 1'b1;
        end else if (bus.en) begin
            valid_r <= v_q[ITER];
            if (v_q[ITER]) begin
                phase_r    <= phase_new;
                mag_r      <= x_q[ITER][XW-1:2];
                freq_r     <= freq_new;
                prev_phase <= phase_new;
                first_flag <= 1'b0;
            end
        end
    end

    assign bus.phase_out = phase_r;
    assign bus.mag_out   = mag_r;
    assign bus.freq_out  = freq_r;
    assign bus.out_valid = valid_r;

endmodule

// File: tb/tb_iq_phase_detector.sv
// Bench for iq_phase_detector: randomized and directed IQ stimulus against an
// atan2/sqrt reference model, scoreboard queues filled by the driver and
// drained by an independent output monitor.
module tb_iq_phase_detector;
  localparam int  DW   = 12;
  localparam int  PW   = 32;
  localparam int  ITER = 16;
  localparam int  LAT  = ITER + 2;
  localparam real PI   = 3.14159265358979323846;
  localparam real FULL = 4294967296.0;
  localparam int  PH_TOL = 1 << 21;
  localparam int  FR_TOL = 1 << 22;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  iq_phase_detector_if #(.DW(DW), .PW(PW)) bus ();

  iq_phase_detector #(.DW(DW), .PW(PW), .ITER(ITER)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [PW-1:0] exp_phase_q[$];
  logic [PW-1:0] exp_freq_q[$];
  int            exp_mag_q[$];
  int            mag_tol_q[$];
  int            ph_tol_q[$];
  int            fr_tol_q[$];
  int            stamp_q[$];

  int            en_edges = 0;
  bit            m_first  = 1'b1;
  logic [PW-1:0] m_prev   = '0;
  real           gain;
  logic [PW-1:0] tone_ph;

  task automatic check(input string name, input bit ok, input longint act, input longint req);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: actual %0d (0x%0h), required %0d (0x%0h) at %0t",
               name, act, act, req, req, $time);
    end
  endtask

  function automatic longint wrap_dist(input logic [PW-1:0] a, input logic [PW-1:0] b);
    logic [PW-1:0] d;
    longint        s;
    d = a - b;
    s = longint'($signed(d));
    return (s < 0) ? -s : s;
  endfunction

  // Ideal phase of an (i,q) point in DDS scaling.
  function automatic logic [PW-1:0] ref_phase(input int i, input int q);
    real    a;
    longint n;
    if (i == 0 && q == 0) return '0;
    a = $atan2(real'(q), real'(i));
    if (a < 0.0) a = a + 2.0 * PI;
    n = longint'(a / (2.0 * PI) * FULL);
    return n[PW-1:0];
  endfunction

  task automatic push_expected(input int i, input int q, input int mtol);
    logic [PW-1:0] ph;
    ph = ref_phase(i, q);
    exp_phase_q.push_back(ph);
    ph_tol_q.push_back((i == 0 && q == 0) ? 0 : PH_TOL);
    exp_mag_q.push_back(int'($sqrt(real'(i * i + q * q)) * gain));
    mag_tol_q.push_back(mtol);
    if (m_first) begin
      exp_freq_q.push_back('0);
      fr_tol_q.push_back(0);
    end else begin
      exp_freq_q.push_back(ph - m_prev);
      fr_tol_q.push_back(FR_TOL);
    end
    m_prev  = ph;
    m_first = 1'b0;
    stamp_q.push_back(en_edges + 1);
  endtask

  task automatic flush_model();
    exp_phase_q.delete();
    exp_freq_q.delete();
    exp_mag_q.delete();
    mag_tol_q.delete();
    ph_tol_q.delete();
    fr_tol_q.delete();
    stamp_q.delete();
    m_first = 1'b1;
    m_prev  = '0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input bit e, input bit v, input int i, input int q, input int mtol);
    @(negedge clk);
    bus.en       = e;
    bus.in_valid = v;
    bus.i_in     = DW'(i);
    bus.q_in     = DW'(q);
    if (e && v) push_expected(i, q, mtol);
  endtask

  // One sample of a DDS tone at the current tone phase; the DDS advances on
  // every enabled cycle whether or not the sample is marked valid.
  task automatic tone_drive(input bit e, input bit v);
    real a;
    int  i;
    int  q;
    a = real'(tone_ph) / FULL * 2.0 * PI;
    i = int'(2047.0 * $cos(a));
    q = int'(2047.0 * $sin(a));
    drive(e, v, i, q, 3);
    if (e) tone_ph = tone_ph + 32'h0100_0000;
  endtask

  task automatic drain();
    for (int n = 0; n < LAT + 10 && exp_phase_q.size() != 0; n++) begin
      drive(1'b1, 1'b0, 0, 0, 0);
    end
    check("drain_empty", exp_phase_q.size() == 0, exp_phase_q.size(), 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_phase"}, bus.phase_out == '0, bus.phase_out, 0);
    check({tag, "_mag"},   bus.mag_out == '0,   bus.mag_out,   0);
    check({tag, "_freq"},  bus.freq_out == '0,  bus.freq_out,  0);
    check({tag, "_valid"}, bus.out_valid == 1'b0, bus.out_valid, 0);
  endtask

  task automatic async_reset();
    @(negedge clk);
    bus.in_valid = 1'b0;
    #2 rst = 1'b1;
    #1 check_outputs_zero("async_rst");
    flush_model();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- output monitor ----------------
  bit            mon_en;
  bit            mon_rst;
  logic [PW-1:0] h_phase;
  logic [PW-1:0] h_freq;
  logic [DW+1:0] h_mag;
  logic          h_valid;

  always begin
    @(posedge clk);
    mon_en  = bus.en;
    mon_rst = rst;
    #1;
    if (!mon_rst && !rst) begin
      if (mon_en) begin
        en_edges++;
        if (bus.out_valid) begin
          if (exp_phase_q.size() == 0) begin
            check("unexpected_output", 1'b0, bus.phase_out, 0);
          end else begin
            logic [PW-1:0] ep;
            logic [PW-1:0] ef;
            int            em;
            int            mt;
            int            pt;
            int            ft;
            int            st;
            int            md;
            ep = exp_phase_q.pop_front();
            ef = exp_freq_q.pop_front();
            em = exp_mag_q.pop_front();
            mt = mag_tol_q.pop_front();
            pt = ph_tol_q.pop_front();
            ft = fr_tol_q.pop_front();
            st = stamp_q.pop_front();
            check("latency", en_edges - st + 1 == LAT, en_edges - st + 1, LAT);
            check("phase", wrap_dist(bus.phase_out, ep) <= pt, bus.phase_out, ep);
            check("freq", wrap_dist(bus.freq_out, ef) <= ft, bus.freq_out, ef);
            md = int'(bus.mag_out) - em;
            check("mag", md <= mt && md >= -mt, bus.mag_out, em);
          end
        end else if (exp_phase_q.size() != 0 && en_edges >= stamp_q[0] + LAT - 1) begin
          check("missing_output", 1'b0, en_edges - stamp_q[0] + 1, LAT);
          void'(exp_phase_q.pop_front());
          void'(exp_freq_q.pop_front());
          void'(exp_mag_q.pop_front());
          void'(mag_tol_q.pop_front());
          void'(ph_tol_q.pop_front());
          void'(fr_tol_q.pop_front());
          void'(stamp_q.pop_front());
        end
      end else begin
        check("hold_en_low",
              {bus.phase_out, bus.mag_out, bus.freq_out, bus.out_valid} ==
              {h_phase, h_mag, h_freq, h_valid},
              bus.phase_out, h_phase);
      end
    end
    h_phase = bus.phase_out;
    h_mag   = bus.mag_out;
    h_freq  = bus.freq_out;
    h_valid = bus.out_valid;
  end

  // ---------------- stimulus ----------------
  initial begin
    int gap;
    gain = 1.0;
    for (int k = 0; k < ITER; k++) begin
      real t;
      t = 1.0;
      for (int j = 0; j < k; j++) t = t / 2.0;
      gain = gain * $sqrt(1.0 + t * t);
    end

    rst          = 1'b1;
    bus.en       = 1'b0;
    bus.in_valid = 1'b0;
    bus.i_in     = '0;
    bus.q_in     = '0;
    tone_ph      = '0;
    repeat (2) @(negedge clk);
    check_outputs_zero("reset_state");
    rst = 1'b0;

    // Idle after reset: nothing may emerge.
    repeat (LAT + 2) drive(1'b1, 1'b0, 0, 0, 0);

    // Continuous tone: first freq is 0, later 0x01000000.
    tone_ph = '0;
    repeat (60) tone_drive(1'b1, 1'b1);
    drain();

    // Cardinal points and extremes.
    drive(1'b1, 1'b1,  2047,     0, 2);
    drive(1'b1, 1'b1,     0,  2047, 2);
    drive(1'b1, 1'b1, -2047,     0, 2);
    drive(1'b1, 1'b1,     0, -2047, 2);
    drive(1'b1, 1'b1, -2048, -2048, 2);
    drive(1'b1, 1'b1,     0,     0, 2);
    drive(1'b1, 1'b1,  2047,  2047, 2);
    drain();

    // Random vectors with random enable and valid gaps.
    for (int n = 0; n < 80; n++) begin
      real a;
      int  amp;
      bit  e;
      bit  v;
      e   = ($urandom_range(0, 5) != 0);
      v   = ($urandom_range(0, 3) != 0);
      amp = $urandom_range(1024, 2047);
      a   = real'($urandom) / FULL * 2.0 * PI;
      drive(e, v, int'(real'(amp) * $cos(a)), int'(real'(amp) * $sin(a)), 3);
    end
    drain();

    // Flow-controlled tone: en low periods and in_valid gaps of 1-5 cycles.
    gap = 0;
    for (int n = 0; n < 200; n++) begin
      bit e;
      bit v;
      e = ($urandom_range(0, 4) != 0);
      v = $urandom_range(0, 1);
      if (e) begin
        if (gap == 0) begin
          v   = 1'b1;
          gap = $urandom_range(1, 5);
        end else begin
          v   = 1'b0;
          gap = gap - 1;
        end
      end
      tone_drive(e, v);
    end

    // Reset while results are in flight, then idle: nothing may emerge.
    async_reset();
    repeat (LAT + 4) drive(1'b1, 1'b0, 0, 0, 0);

    // Restart the tone across the phase wrap; first result has freq 0.
    tone_ph = 32'hE000_0000;
    repeat (60) tone_drive(1'b1, 1'b1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
